// File: rtl/cache_axi_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_axi_bridge_pkg
// Description : Shared types and helpers for the cache-to-AXI4 bridge:
//               request type codes, AXI burst encoding, FSM state enums and
//               the uncached write-strobe generator.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_axi_bridge_pkg;

  // Cache request type codes (rd_type / wr_type)
  localparam logic [2:0] TYPE_BYTE = 3'b000;
  localparam logic [2:0] TYPE_HALF = 3'b001;
  localparam logic [2:0] TYPE_WORD = 3'b010;
  localparam logic [2:0] TYPE_LINE = 3'b100;

  // AXI burst type: incrementing
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wr_state_t;

  // Byte-lane strobe for a single-beat write; lines and words use all lanes.
  function automatic logic [3:0] gen_wstrb(input logic [2:0] req_type,
                                           input logic [1:0] offset);
    case (req_type)
      TYPE_BYTE: return 4'b0001 << offset;
      TYPE_HALF: return 4'b0011 << offset;
      default:   return 4'b1111;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module      : cache_axi_bridge
// Description : Converts the cache line/word request interface into AXI4
//               master read (AR/R) and write (AW/W/B) bursts. Read and write
//               engines run independently; a read to the line held in the
//               write buffer is stalled until that write is acknowledged.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_axi_bridge
  import cache_axi_bridge_pkg::*;
#(
  parameter int ID_W  = 4,
  parameter int RD_ID = 0,
  parameter int WR_ID = 1
) (
  input  logic            clk,
  input  logic            reset,
  // cache read request / return
  input  logic            rd_req,
  input  logic [2:0]      rd_type,
  input  logic [31:0]     rd_addr,
  output logic            rd_rdy,
  output logic            ret_valid,
  output logic            ret_last,
  output logic [31:0]     ret_data,
  // cache write request
  input  logic            wr_req,
  input  logic [2:0]      wr_type,
  input  logic [31:0]     wr_addr,
  input  logic [3:0]      wr_wstrb,
  input  logic [127:0]    wr_data,
  output logic            wr_rdy,
  // AXI AR
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic            arvalid,
  input  logic            arready,
  // AXI R
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready,
  // AXI AW
  output logic [ID_W-1:0] awid,
  output logic [31:0]     awaddr,
  output logic [7:0]      awlen,
  output logic [2:0]      awsize,
  output logic [1:0]      awburst,
  output logic            awvalid,
  input  logic            awready,
  // AXI W
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  // AXI B
  input  logic [ID_W-1:0] bid,
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready
);

  rd_state_t    rd_state, rd_next;
  wr_state_t    wr_state, wr_next;
  logic [31:0]  rd_addr_q;
  logic [2:0]   rd_type_q;
  logic [31:0]  wr_addr_q;
  logic [2:0]   wr_type_q;
  logic [127:0] wr_buf;
  logic [1:0]   wcnt;
  logic         hazard;
  logic         rd_line;
  logic         wr_line;

  // Response IDs/status and the cache byte mask carry no information we use.
  logic unused_inputs;
  assign unused_inputs = ^{wr_wstrb, rid, rresp, bid, bresp};

  assign rd_line = (rd_type_q == TYPE_LINE);
  assign wr_line = (wr_type_q == TYPE_LINE);

  // Read-after-write on the buffered line must wait for the write's B response.
  assign hazard = (wr_state != W_IDLE) && (rd_addr[31:4] == wr_addr_q[31:4]);

  // --------------------------------------------------------------------------
  // Read engine
  // --------------------------------------------------------------------------

  // Read FSM state register
  always_ff @(posedge clk) begin
    if (reset) rd_state <= R_IDLE;
    else       rd_state <= rd_next;
  end

  // Read FSM next-state logic
  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE:  if (rd_req && rd_rdy)  rd_next = R_ADDR;
      R_ADDR:  if (arready)           rd_next = R_DATA;
      R_DATA:  if (rvalid && rlast)   rd_next = R_IDLE;
      default:                        rd_next = R_IDLE;
    endcase
  end

  // Read FSM outputs; returned beats pass straight through to the cache
  always_comb begin
    rd_rdy    = !reset && (rd_state == R_IDLE) && !hazard;
    arvalid   = (rd_state == R_ADDR);
    rready    = (rd_state == R_DATA);
    ret_valid = rready && rvalid;
  end

  // Capture the accepted read request so AR payload stays stable until arready
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr_q <= '0;
      rd_type_q <= '0;
    end else if (rd_req && rd_rdy) begin
      rd_addr_q <= rd_addr;
      rd_type_q <= rd_type;
    end
  end

  assign arid     = ID_W'(RD_ID);
  assign araddr   = rd_line ? {rd_addr_q[31:4], 4'b0000} : rd_addr_q;
  assign arlen    = rd_line ? 8'd3 : 8'd0;
  assign arsize   = rd_line ? 3'd2 : {1'b0, rd_type_q[1:0]};
  assign arburst  = BURST_INCR;
  assign ret_last = rlast;
  assign ret_data = rdata;

  // --------------------------------------------------------------------------
  // Write engine
  // --------------------------------------------------------------------------

  // Write FSM state register
  always_ff @(posedge clk) begin
    if (reset) wr_state <= W_IDLE;
    else       wr_state <= wr_next;
  end

  // Write FSM next-state logic
  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE:  if (wr_req && wr_rdy)  wr_next = W_ADDR;
      W_ADDR:  if (awready)           wr_next = W_DATA;
      W_DATA:  if (wready && wlast)   wr_next = W_RESP;
      W_RESP:  if (bvalid)            wr_next = W_IDLE;
      default:                        wr_next = W_IDLE;
    endcase
  end

  // Write FSM outputs; W payload is driven only while a beat is offered
  always_comb begin
    wr_rdy  = !reset && (wr_state == W_IDLE);
    awvalid = (wr_state == W_ADDR);
    wvalid  = (wr_state == W_DATA);
    bready  = (wr_state == W_RESP);
    wdata   = '0;
    wstrb   = '0;
    wlast   = 1'b0;
    if (wr_state == W_DATA) begin
      wdata = wr_buf[{wcnt, 5'b00000} +: 32];
      wstrb = gen_wstrb(wr_type_q, wr_addr_q[1:0]);
      wlast = wr_line ? (wcnt == 2'd3) : 1'b1;
    end
  end

  // Write buffer capture and beat counter (restarts after the last beat)
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_addr_q <= '0;
      wr_type_q <= '0;
      wr_buf    <= '0;
      wcnt      <= '0;
    end else if (wr_req && wr_rdy) begin
      wr_addr_q <= wr_addr;
      wr_type_q <= wr_type;
      wr_buf    <= wr_data;
      wcnt      <= '0;
    end else if (wvalid && wready) begin
      wcnt      <= wlast ? 2'd0 : wcnt + 2'd1;
    end
  end

  assign awid    = ID_W'(WR_ID);
  assign awaddr  = wr_line ? {wr_addr_q[31:4], 4'b0000} : wr_addr_q;
  assign awlen   = wr_line ? 8'd3 : 8'd0;
  assign awsize  = wr_line ? 3'd2 : {1'b0, wr_type_q[1:0]};
  assign awburst = BURST_INCR;

endmodule
`default_nettype wire

// File: tb/tb_cache_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_axi_bridge
// Description : Self-checking bench for cache_axi_bridge. Acts as both the
//               cache and an AXI slave with random stalls; expected AXI
//               encodings and beat data come from a request-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_axi_bridge;
  import cache_axi_bridge_pkg::*;

  localparam int ID_W = 4;

  logic clk = 1'b0;
  logic reset;
  logic rd_req, rd_rdy, ret_valid, ret_last;
  logic [2:0] rd_type;
  logic [31:0] rd_addr, ret_data;
  logic wr_req, wr_rdy;
  logic [2:0] wr_type;
  logic [31:0] wr_addr;
  logic [3:0] wr_wstrb;
  logic [127:0] wr_data;
  logic [ID_W-1:0] arid, rid, awid, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize;
  logic [1:0] arburst, rresp, awburst, bresp;
  logic arvalid, arready, rlast, rvalid, rready;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0] wstrb;

  int n_checks = 0;
  int n_errors = 0;

  cache_axi_bridge #(.ID_W(ID_W), .RD_ID(0), .WR_ID(1)) dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  // Global time bound so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- request-level reference model ----------------
  function automatic int beats_for(input logic [2:0] t);
    return (t == TYPE_LINE) ? 4 : 1;
  endfunction

  function automatic logic [31:0] exp_addr(input logic [31:0] a, input logic [2:0] t);
    return (t == TYPE_LINE) ? (a / 16) * 16 : a;
  endfunction

  function automatic logic [2:0] exp_size(input logic [2:0] t);
    return (t == TYPE_LINE) ? 3'd2 : t;
  endfunction

  function automatic logic [3:0] exp_strb(input logic [2:0] t, input logic [31:0] a);
    int sh;
    sh = int'(a % 4);
    if (t == TYPE_BYTE) return 4'((1 << sh) & 15);
    if (t == TYPE_HALF) return 4'((3 << sh) & 15);
    return 4'hF;
  endfunction

  // Full read transaction; starts and ends just after a rising edge
  task automatic do_read(input logic [31:0] addr, input logic [2:0] t, input bit immediate);
    int n, w, k;
    logic [31:0] d, ea;
    n  = beats_for(t);
    ea = exp_addr(addr, t);
    rd_req = 1'b1; rd_addr = addr; rd_type = t;
    #1;
    if (immediate) check("rd_rdy immediate", rd_rdy, 1'b1);
    w = 0;
    while (!rd_rdy && w < 100) begin tick(); #1; w++; end
    check("rd_rdy accept", rd_rdy, 1'b1);
    tick();
    rd_req = 1'b0; rd_addr = ~addr; rd_type = TYPE_BYTE;
    #1;
    check("arvalid", arvalid, 1'b1);
    check("araddr", araddr, ea);
    check("arlen", arlen, 8'(n - 1));
    check("arsize", arsize, exp_size(t));
    check("arburst", arburst, 2'b01);
    check("arid", arid, 4'd0);
    k = $urandom_range(0, 3);
    repeat (k) begin
      tick(); #1;
      check("arvalid hold", arvalid, 1'b1);
      check("araddr hold", araddr, ea);
    end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    #1;
    check("arvalid drop", arvalid, 1'b0);
    for (int i = 0; i < n; i++) begin
      k = $urandom_range(0, 2);
      repeat (k) begin
        check("rready", rready, 1'b1);
        check("ret_valid idle", ret_valid, 1'b0);
        tick(); #1;
      end
      d = $urandom;
      rvalid = 1'b1; rdata = d; rlast = (i == n - 1); rid = '0; rresp = 2'($urandom);
      #1;
      check("ret_valid", ret_valid, 1'b1);
      check("ret_data", ret_data, d);
      check("ret_last", ret_last, (i == n - 1));
      tick();
      rvalid = 1'b0; rlast = 1'b0;
      #1;
    end
    check("rready after last", rready, 1'b0);
    check("rd_rdy after last", rd_rdy, 1'b1);
    tick();
  endtask

  // Write request through the last W beat; leaves the bridge waiting for B
  task automatic do_write_start(input logic [31:0] addr, input logic [2:0] t,
                                input logic [127:0] data);
    int n, w, k, i;
    bit r;
    logic [31:0] ea;
    n  = beats_for(t);
    ea = exp_addr(addr, t);
    wr_req = 1'b1; wr_addr = addr; wr_type = t; wr_data = data; wr_wstrb = 4'($urandom);
    #1;
    w = 0;
    while (!wr_rdy && w < 100) begin tick(); #1; w++; end
    check("wr_rdy accept", wr_rdy, 1'b1);
    tick();
    wr_req = 1'b0; wr_addr = ~addr; wr_data = ~data;
    #1;
    check("awvalid", awvalid, 1'b1);
    check("awaddr", awaddr, ea);
    check("awlen", awlen, 8'(n - 1));
    check("awsize", awsize, exp_size(t));
    check("awburst", awburst, 2'b01);
    check("awid", awid, 4'd1);
    check("wvalid before aw", wvalid, 1'b0);
    check("wr_rdy busy", wr_rdy, 1'b0);
    k = $urandom_range(0, 3);
    repeat (k) begin
      tick(); #1;
      check("awvalid hold", awvalid, 1'b1);
      check("awaddr hold", awaddr, ea);
    end
    awready = 1'b1;
    tick();
    awready = 1'b0;
    #1;
    check("awvalid drop", awvalid, 1'b0);
    i = 0; w = 0;
    while (i < n && w < 64) begin
      check("wvalid", wvalid, 1'b1);
      check("wdata", wdata, data[32*i +: 32]);
      check("wstrb", wstrb, exp_strb(t, addr));
      check("wlast", wlast, (i == n - 1));
      r = 1'($urandom_range(0, 1));
      wready = r;
      tick();
      wready = 1'b0;
      if (r) i++;
      w++;
      #1;
    end
    check("w beat count", i, n);
    check("wvalid after last", wvalid, 1'b0);
    check("bready", bready, 1'b1);
    tick();
  endtask

  // B response after a delay; wr_rdy must rise the cycle after the handshake
  task automatic do_write_finish(input int bdelay);
    repeat (bdelay) begin
      #1;
      check("bready wait", bready, 1'b1);
      check("wr_rdy wait", wr_rdy, 1'b0);
      tick();
    end
    bvalid = 1'b1; bid = 4'd1; bresp = 2'b00;
    #1;
    check("wr_rdy at b", wr_rdy, 1'b0);
    tick();
    bvalid = 1'b0;
    #1;
    check("wr_rdy after b", wr_rdy, 1'b1);
    check("bready after b", bready, 1'b0);
    tick();
  endtask

  logic [2:0] types [4] = '{TYPE_BYTE, TYPE_HALF, TYPE_WORD, TYPE_LINE};

  initial begin
    logic [31:0] a;
    logic [2:0] t;
    logic [127:0] d;

    reset = 1'b1;
    rd_req = 0; rd_type = 0; rd_addr = 0;
    wr_req = 0; wr_type = 0; wr_addr = 0; wr_wstrb = 0; wr_data = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;

    // Reset state
    repeat (3) tick();
    #1;
    check("reset rd_rdy", rd_rdy, 1'b0);
    check("reset wr_rdy", wr_rdy, 1'b0);
    check("reset arvalid", arvalid, 1'b0);
    check("reset awvalid", awvalid, 1'b0);
    check("reset wvalid", wvalid, 1'b0);
    check("reset rready", rready, 1'b0);
    check("reset bready", bready, 1'b0);
    check("reset ret_valid", ret_valid, 1'b0);
    check("reset araddr", araddr, 32'h0);
    check("reset awaddr", awaddr, 32'h0);
    check("reset wdata", wdata, 32'h0);
    reset = 1'b0;
    #1;
    check("post-reset rd_rdy", rd_rdy, 1'b1);
    check("post-reset wr_rdy", wr_rdy, 1'b1);
    tick();

    // Directed cases
    do_read(32'h1000_0040, TYPE_LINE, 1'b1);
    do_read(32'h1FD0_0003, TYPE_BYTE, 1'b1);
    do_write_start(32'h2000_0010, TYPE_LINE,
                   128'h4444_4444_3333_3333_2222_2222_1111_1111);
    do_write_finish(3);
    do_write_start(32'h1FD0_0002, TYPE_HALF, 128'h0 | 32'hABCD_0000);
    do_write_finish(0);

    // Read-after-write hazard on the buffered line
    do_write_start(32'h3000_0020, TYPE_LINE, {$urandom, $urandom, $urandom, $urandom});
    do_read(32'h3000_0030, TYPE_WORD, 1'b1);
    rd_req = 1'b1; rd_addr = 32'h3000_002C; rd_type = TYPE_WORD;
    repeat (10) begin
      #1;
      check("hazard rd_rdy", rd_rdy, 1'b0);
      tick();
    end
    bvalid = 1'b1; bid = 4'd1;
    #1;
    check("hazard rd_rdy at b", rd_rdy, 1'b0);
    tick();
    bvalid = 1'b0;
    do_read(32'h3000_002C, TYPE_WORD, 1'b1);

    // Reset during the second beat of a line read
    rd_req = 1'b1; rd_addr = 32'h4000_0044; rd_type = TYPE_LINE;
    #1;
    check("pre-reset rd_rdy", rd_rdy, 1'b1);
    tick();
    rd_req = 1'b0; arready = 1'b1;
    tick();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'hAAAA_0001; rlast = 1'b0;
    tick();
    rdata = 32'hAAAA_0002; reset = 1'b1;
    #1;
    check("beat2 ret_valid", ret_valid, 1'b1);
    tick();
    #1;
    check("mid-reset rready", rready, 1'b0);
    check("mid-reset arvalid", arvalid, 1'b0);
    check("mid-reset ret_valid", ret_valid, 1'b0);
    check("mid-reset rd_rdy", rd_rdy, 1'b0);
    reset = 1'b0; rvalid = 1'b0;
    #1;
    check("after reset rd_rdy", rd_rdy, 1'b1);
    tick();
    do_read(32'h5000_0100, TYPE_LINE, 1'b1);

    // Randomized transactions
    for (int it = 0; it < 24; it++) begin
      t = types[$urandom_range(0, 3)];
      a = $urandom;
      if (t == TYPE_HALF) a[0] = 1'b0;
      if (t == TYPE_WORD) a[1:0] = 2'b00;
      if ($urandom_range(0, 1) == 0) begin
        do_read(a, t, 1'b1);
      end else begin
        d = {$urandom, $urandom, $urandom, $urandom};
        do_write_start(a, t, d);
        do_write_finish($urandom_range(0, 4));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
